// File: rtl/prng_arbiter_pkg.sv
// Shared types and helpers for the LFSR-backed round-robin random-byte arbiter.
package prng_arbiter_pkg;

  localparam logic [7:0] SEED_DEFAULT = 8'hDA;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_e;

  // Taps 8,6,5,4: maximal-length, so a non-zero state never reaches zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/prng_arbiter_rr.sv
// Combinational round-robin selector: first set request at or after ptr+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Hands out one LFSR byte per cycle to round-robin-selected requesters after
// a short warm-up following reset or reseed.
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter logic [7:0] SEED    = SEED_DEFAULT,
  parameter int         WARMUP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_reseed,
  input  logic [7:0]         i_seed,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [7:0]         o_rnd,
  output logic               o_valid,
  output logic               o_busy,
  output logic [15:0]        o_draws
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state;
  logic [7:0]         lfsr;
  logic [3:0]         wcnt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req (i_req),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_idx = PW'(i);
  end

  assign o_busy = (state == ST_WARMUP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_WARMUP;
      lfsr    <= SEED;
      wcnt    <= '0;
      ptr     <= PW'(NUM_REQ - 1);
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_rnd   <= 8'h00;
      o_draws <= '0;
    end else begin
      o_gnt   <= '0;
      o_valid <= 1'b0;
      if (i_reseed) begin
        // A zero seed would lock the LFSR, so fall back to the default.
        lfsr  <= (i_seed == 8'h00) ? SEED : i_seed;
        state <= ST_WARMUP;
        wcnt  <= '0;
      end else begin
        case (state)
          ST_WARMUP: begin
            lfsr <= lfsr_step(lfsr);
            if (wcnt == 4'(WARMUP - 1)) begin
              state <= ST_SERVE;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
          ST_SERVE: begin
            if (|i_req) begin
              o_gnt   <= gnt;
              o_valid <= 1'b1;
              o_rnd   <= lfsr;
              lfsr    <= lfsr_step(lfsr);
              ptr     <= gnt_idx;
              o_draws <= o_draws + 16'd1;
            end
          end
          default: state <= ST_WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prng_arbiter.sv
// Scoreboard bench for prng_arbiter: expected grants are queued as stimulus is
// driven and popped as the DUT presents o_valid.
module tb_prng_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  i_req;
  logic        i_reseed;
  logic [7:0]  i_seed;
  logic [3:0]  o_gnt;
  logic [7:0]  o_rnd;
  logic        o_valid;
  logic        o_busy;
  logic [15:0] o_draws;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [7:0]  rnd;
    logic [15:0] draws;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  prng_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_reseed (i_reseed),
    .i_seed   (i_seed),
    .o_gnt    (o_gnt),
    .o_rnd    (o_rnd),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_draws  (o_draws)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; i_req = '0; i_reseed = 1'b0; i_seed = '0;
    repeat (2) @(negedge clk);
    total++;
    if (o_gnt !== 4'b0 || o_valid !== 1'b0 || o_rnd !== 8'h00 || o_busy !== 1'b1 || o_draws !== 16'h0)
      $display("FAIL reset_state: gnt=%b valid=%b rnd=%h busy=%b draws=%h, want 0000/0/00/1/0000",
               o_gnt, o_valid, o_rnd, o_busy, o_draws);
    else passed++;
  endtask

  task automatic test_first_grants();
    int busy_n, cyc;
    exp_t e;
    reset = 1'b0; i_req = 4'b0001;
    sb_q.push_back('{4'b0001, 8'h6B, 16'd1});
    sb_q.push_back('{4'b0001, 8'hD6, 16'd2});
    sb_q.push_back('{4'b0001, 8'hAC, 16'd3});
    #1;
    busy_n = 0; cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      if (o_busy === 1'b1) busy_n++;
      @(negedge clk); cyc++;
    end
    total++;
    if (busy_n != 2) $display("FAIL first_busy: busy cycles=%0d, want 2", busy_n); else passed++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws)
        $display("FAIL first_grant: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
                 o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
      else passed++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_grant();
    total++;
    if (o_valid !== 1'b1) $display("FAIL mid_pre: valid=%b, want 1", o_valid); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (o_gnt !== 4'b0 || o_valid !== 1'b0 || o_draws !== 16'h0 || o_busy !== 1'b1)
      $display("FAIL mid_reset: gnt=%b valid=%b draws=%h busy=%b, want 0000/0/0000/1",
               o_gnt, o_valid, o_draws, o_busy);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_round_robin(output logic [7:0] lfsr_m);
    int busy_n, cyc;
    exp_t e;
    logic [7:0] r;
    reset = 1'b0; i_req = 4'b1111;
    r = 8'h6B;
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back('{4'b0001 << (k % 4), r, 16'(k + 1)});
      r = m_step(r);
    end
    lfsr_m = r;
    #1;
    busy_n = 0; cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      if (o_busy === 1'b1) busy_n++;
      @(negedge clk); cyc++;
    end
    total++;
    if (busy_n != 2 || o_valid !== 1'b1) $display("FAIL rr_start: busy=%0d valid=%b, want 2 1", busy_n, o_valid);
    else passed++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws)
        $display("FAIL rr_grant: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
                 o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
      else passed++;
      if (sb_q.size() > 0) @(negedge clk);
    end
    i_req = 4'b0000;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_gnt !== 4'b0 || o_draws !== 16'd8 || o_rnd !== e.rnd)
      $display("FAIL rr_idle: valid=%b gnt=%b draws=%0d rnd=%h, want 0 0000 8 %h",
               o_valid, o_gnt, o_draws, o_rnd, e.rnd);
    else passed++;
  endtask

  task automatic test_idle_hold(input logic [7:0] lfsr_m);
    exp_t e;
    repeat (5) @(negedge clk);
    i_req = 4'b0001;
    sb_q.push_back('{4'b0001, lfsr_m, 16'd9});
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws)
      $display("FAIL idle_hold: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
               o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
    else passed++;
    i_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reseed(input logic [7:0] seed, input logic [3:0] req,
                             input logic [7:0] first_rnd, input logic [15:0] draws);
    int busy_n, cyc;
    exp_t e;
    i_reseed = 1'b1; i_seed = seed; i_req = req;
    sb_q.push_back('{req, first_rnd, draws});
    @(negedge clk);
    i_reseed = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL reseed_edge seed=%h: valid=%b busy=%b, want 0 1", seed, o_valid, o_busy);
    else passed++;
    #1;
    busy_n = 0; cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      if (o_busy === 1'b1) busy_n++;
      @(negedge clk); cyc++;
    end
    total++;
    if (busy_n != 2) $display("FAIL reseed_busy seed=%h: busy=%0d, want 2", seed, busy_n); else passed++;
    e = sb_q.pop_front();
    total++;
    if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws)
      $display("FAIL reseed_grant seed=%h: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
               seed, o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
    else passed++;
    i_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reseed_mid();
    int busy_n, cyc;
    exp_t e;
    logic [7:0] w;
    i_reseed = 1'b1; i_seed = 8'h5A; i_req = 4'b1001;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) $display("FAIL mid_rs1: valid=%b busy=%b, want 0 1", o_valid, o_busy);
    else passed++;
    i_seed = 8'h3C;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) $display("FAIL mid_rs2: valid=%b busy=%b, want 0 1", o_valid, o_busy);
    else passed++;
    i_reseed = 1'b0;
    w = m_step(m_step(8'h3C));
    sb_q.push_back('{4'b1000, w, 16'd12});
    sb_q.push_back('{4'b0001, m_step(w), 16'd13});
    #1;
    busy_n = 0; cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      if (o_busy === 1'b1) busy_n++;
      @(negedge clk); cyc++;
    end
    total++;
    if (busy_n != 2) $display("FAIL mid_warm: busy=%0d, want 2", busy_n); else passed++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws || o_rnd === 8'h00)
        $display("FAIL mid_grant_a: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
                 o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
      else passed++;
      if (sb_q.size() > 0) @(negedge clk);
    end
    // Reseed while grants are flowing: the edge that would have granted must not.
    i_reseed = 1'b1; i_seed = 8'hC3;
    @(negedge clk);
    i_reseed = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_gnt !== 4'b0 || o_draws !== 16'd13)
      $display("FAIL mid_noreseed_gnt: valid=%b gnt=%b draws=%0d, want 0 0000 13", o_valid, o_gnt, o_draws);
    else passed++;
    w = m_step(m_step(8'hC3));
    sb_q.push_back('{4'b1000, w, 16'd14});
    sb_q.push_back('{4'b0001, m_step(w), 16'd15});
    #1;
    busy_n = 0; cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      if (o_busy === 1'b1) busy_n++;
      @(negedge clk); cyc++;
    end
    total++;
    if (busy_n != 2) $display("FAIL mid_warm2: busy=%0d, want 2", busy_n); else passed++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (o_valid !== 1'b1 || o_gnt !== e.gnt || o_rnd !== e.rnd || o_draws !== e.draws || o_rnd === 8'h00)
        $display("FAIL mid_grant_b: valid=%b gnt=%b rnd=%h draws=%0d, want 1 %b %h %0d",
                 o_valid, o_gnt, o_rnd, o_draws, e.gnt, e.rnd, e.draws);
      else passed++;
      if (sb_q.size() > 0) @(negedge clk);
    end
    i_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_draws_wrap();
    int cyc, zeros;
    i_req = 4'b1111;
    cyc = 0; zeros = 0;
    do begin
      @(negedge clk); cyc++;
      if (o_valid === 1'b1 && o_rnd === 8'h00) zeros++;
    end while (o_draws !== 16'hFFFF && cyc < 70000);
    total++;
    if (o_draws !== 16'hFFFF || cyc != 65520)
      $display("FAIL wrap_reach: draws=%h cycles=%0d, want FFFF 65520", o_draws, cyc);
    else passed++;
    total++;
    if (zeros != 0) $display("FAIL zero_rnd: zero bytes=%0d, want 0", zeros); else passed++;
    @(negedge clk);
    total++;
    if (o_draws !== 16'h0000 || o_valid !== 1'b1)
      $display("FAIL wrap_zero: draws=%h valid=%b, want 0000 1", o_draws, o_valid);
    else passed++;
    i_req = 4'b0000;
    @(negedge clk);
    total++;
    if (o_draws !== 16'h0000 || o_valid !== 1'b0)
      $display("FAIL wrap_idle: draws=%h valid=%b, want 0000 0", o_draws, o_valid);
    else passed++;
  endtask

  initial begin
    logic [7:0] lfsr_m;
    test_reset();
    test_first_grants();
    test_reset_mid_grant();
    test_round_robin(lfsr_m);
    test_idle_hold(lfsr_m);
    test_reseed(8'h01, 4'b0100, 8'h04, 16'd10);
    test_reseed(8'h00, 4'b0010, 8'h6B, 16'd11);
    test_reseed_mid();
    test_draws_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
